fm7_main_irq_ctrl: RTL and testbench
====================================

// Module: fm7_main_irq_ctrl
// PURPOSE
// Main-CPU interrupt controller. Snoops the buffered 6809 bus (address, write data, RWB, EB)
// and drives IRQn/FIRQn back into the main CPU wrapper. Owns the I/O registers at
// $FD02 (IRQ mask), $FD03 (IRQ status) and $FD04 (FIRQ status), the 2.03 ms interval
// timer, and the edge latches for the keyboard, printer, sub-CPU attention and BREAK sources.
// PARAMETERS
// TIMER_DIV   36864   CLKSYS cycles per timer tick; 16-bit counter, legal range 2..65535
// SYNC_STAGES 2       synchroniser depth for asynchronous source inputs
// PORTS
// CLKSYS      in   1   system clock; all state changes on its rising edge
// RESETn      in   1   asynchronous active-low reset
// MADDRBUS    in   16  main CPU address
// MDATA_W     in   8   main CPU write data
// RWB         in   1   buffered R/W (1 = read)
// EB          in   1   buffered E; an access completes on its falling edge
// KEYIRQ      in   1   keyboard data-ready level, async; rising edge sets KEY flag
// PRNACKn     in   1   printer acknowledge, async; falling edge sets PRN flag
// EXTIRQn     in   1   external IRQ level, async; synchronised only, not latched
// ATTNP       in   1   sub-CPU attention pulse, CLKSYS domain, one cycle wide
// BREAKn      in   1   BREAK key, async; falling edge sets BRK flag
// IRQn        out  1   to main CPU IRQ, active low
// FIRQn       out  1   to main CPU FIRQ, active low
// DOUT        out  8   read data for the main data-bus mux
// DOE         out  1   DOUT valid; mux selects DOUT when high
// BEHAVIOUR
// - Reset (async): mask=8'h00; KEY/PRN/TMR/ATT/BRK flags=0; timer count=0; sync chains=idle level.
//   IRQn=1, FIRQn=1, DOUT=8'hFF, DOE=0 for the whole reset and after release.
// - Access strobe: register EB once (eb_d). acc = eb_d & ~EB, one cycle per bus cycle.
//   Register writes and read side effects happen only on acc. DOUT/DOE are combinational.
// - Decode: full 16-bit compare on MADDRBUS.
//   DOE = RWB & EB & (addr is $FD03 or $FD04). DOUT=8'hFF when DOE=0.
// - $FD02 write (acc & ~RWB): mask <= MDATA_W[3:0]; 1 = enabled. Bits 0..3 = KEY, PRN, TMR, EXT.
//   $FD02 reads are not decoded (DOE=0).
// - $FD03 read: DOUT = {4'hF, ~EXT, ~TMR, ~PRN, ~KEY}; flags are active low in the data.
//   Shown unmasked. On acc, clear TMR and PRN.
// - $FD04 read: DOUT = {6'h3F, ~BRK, ~ATT}. On acc, clear ATT and BRK.
// - Any read of $FD01 on acc clears KEY (keyboard data read). Nothing is returned here for $FD01.
// - Async inputs: SYNC_STAGES flops, then a 1-flop edge detector. The flag sets on the
//   (SYNC_STAGES+1)th rising edge after the input change.
// - EXT = synchronised ~EXTIRQn.
// - Timer: counter runs free from reset release, 0..TIMER_DIV-1.
//   At TIMER_DIV-1 it wraps to 0 and sets TMR in the same edge.
//   The counter does not stop while TMR is already set; TMR is a single sticky bit.
// - Set/clear collision: if a set event and a clearing acc fall in the same cycle, set wins.
//   The flag stays 1 and the event is not lost.
// - IRQn  = ~|({EXT,TMR,PRN,KEY} & mask). Combinational from registered state.
//   Asserts in the same cycle the flag sets.
// - FIRQn = ~(ATT | BRK). Not maskable.
// - Reset mid-access: an access cut by RESETn has no effect. eb_d resets to 0, so no spurious acc.
// STRUCTURE
// - Package fm7_io_pkg: address constants (FD01/FD02/FD03/FD04) and bit indices for KEY/PRN/TMR/EXT,
//   ATT/BRK.
// - Sub-module fm7_sync_edge (param STAGES, RISE): synchroniser plus edge pulse.
//   Instantiated 3x (KEY rise, PRN fall, BRK fall). EXT uses the synchroniser path with no edge.
// - Top level holds the timer, flag registers, mask, decode and output logic.
// TESTING (bench TIMER_DIV=16, SYNC_STAGES=2)
// - Reset: hold RESETn=0 with toggling inputs -> IRQn=1, FIRQn=1, DOE=0.
//   Read $FD03 after release -> 8'hFF.
// - Timer: write $FD02=8'h04. TMR sets 16 clocks after release -> IRQn=0; $FD03 reads 8'hFB.
//   After that read's E fall -> IRQn=1. Next tick follows 16 clocks after the previous one.
// - Mask: mask=0, raise KEYIRQ -> IRQn stays 1, $FD03=8'hFE.
//   Write mask=8'h01 -> IRQn=0 the cycle after acc. Read $FD01 -> IRQn=1.
// - Latency: PRNACKn falls -> PRN flag set on the 3rd CLKSYS edge.
//   A 1-cycle ATTNP -> FIRQn=0 next cycle; read $FD04 -> 8'hFE, then FIRQn=1.
// - Collision: timer wrap in the same cycle as a $FD03 read acc -> TMR remains 1, IRQn stays 0.
// - Mid-access reset: assert RESETn=0 while EB=1 on a $FD02 write -> mask=0 after release.
//   No flag is cleared or set by the aborted cycle.

Source files
------------

// File: rtl/fm7_io_pkg.sv
// Shared constants for the FM-7 main-CPU I/O block.
// Holds the decoded register addresses and the bit positions of each
// interrupt source inside the IRQ ($FD03) and FIRQ ($FD04) groups.
package fm7_io_pkg;

    localparam logic [15:0] ADDR_FD01 = 16'hFD01;  // keyboard data (read clears KEY)
    localparam logic [15:0] ADDR_FD02 = 16'hFD02;  // IRQ mask (write only)
    localparam logic [15:0] ADDR_FD03 = 16'hFD03;  // IRQ status (read, active-low flags)
    localparam logic [15:0] ADDR_FD04 = 16'hFD04;  // FIRQ status (read, active-low flags)

    // IRQ group, shared by the mask register and the $FD03 status byte
    localparam int KEY_BIT = 0;
    localparam int PRN_BIT = 1;
    localparam int TMR_BIT = 2;
    localparam int EXT_BIT = 3;

    // FIRQ group, $FD04 status byte
    localparam int ATT_BIT = 0;
    localparam int BRK_BIT = 1;

endpackage

// File: rtl/fm7_sync_edge.sv
// Synchroniser plus single-cycle edge pulse for an asynchronous source.
// Ports:
//   clk   - system clock
//   rst_n - asynchronous active-low reset; chain and edge flop go to the idle level
//   din   - asynchronous input
//   pulse - one-cycle pulse after the selected edge has passed STAGES flops
// RISE=1 detects 0->1 (idle low), RISE=0 detects 1->0 (idle high).
module fm7_sync_edge #(
    parameter int STAGES = 2,
    parameter bit RISE   = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic pulse
);

    localparam logic IDLE = !RISE;

    logic [STAGES-1:0] chain;
    logic              prev;
    logic              level;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= {STAGES{IDLE}};
            prev  <= IDLE;
        end else begin
            chain[0] <= din;
            for (int i = 1; i < STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
            prev <= chain[STAGES-1];
        end
    end

    assign level = chain[STAGES-1];
    assign pulse = RISE ? (level & ~prev) : (~level & prev);

endmodule

// File: rtl/fm7_main_irq_ctrl.sv
// FM-7 main-CPU interrupt controller.
// Snoops the buffered 6809 bus and drives IRQn/FIRQn to the main CPU.
// Registers: $FD02 IRQ mask (W), $FD03 IRQ status (R), $FD04 FIRQ status (R);
// a read of $FD01 acknowledges the keyboard flag.
// Ports:
//   CLKSYS, RESETn        - system clock, async active-low reset
//   MADDRBUS, MDATA_W     - CPU address and write data
//   RWB, EB               - buffered R/W (1 = read) and E; access completes on EB fall
//   KEYIRQ, PRNACKn,
//   EXTIRQn, BREAKn       - asynchronous interrupt sources
//   ATTNP                 - sub-CPU attention pulse, CLKSYS domain
//   IRQn, FIRQn           - active-low interrupt requests
//   DOUT, DOE             - read data and its valid for the data-bus mux
module fm7_main_irq_ctrl
    import fm7_io_pkg::*;
#(
    parameter int TIMER_DIV   = 36864,
    parameter int SYNC_STAGES = 2
) (
    input  logic        CLKSYS,
    input  logic        RESETn,
    input  logic [15:0] MADDRBUS,
    input  logic [7:0]  MDATA_W,
    input  logic        RWB,
    input  logic        EB,
    input  logic        KEYIRQ,
    input  logic        PRNACKn,
    input  logic        EXTIRQn,
    input  logic        ATTNP,
    input  logic        BREAKn,
    output logic        IRQn,
    output logic        FIRQn,
    output logic [7:0]  DOUT,
    output logic        DOE
);

    localparam logic [15:0] TMR_LAST = 16'(TIMER_DIV - 1);

    logic [15:0] tmr_cnt;
    logic        tmr_tick;
    logic        eb_d;
    logic        acc;
    logic        hit_fd01, hit_fd02, hit_fd03, hit_fd04;
    logic        key_set, prn_set, brk_set;
    logic        key_f, prn_f, tmr_f, att_f, brk_f;
    logic [3:0]  mask;
    logic [SYNC_STAGES-1:0] ext_sync;
    logic        ext;
    logic [3:0]  irq_src;
    logic [1:0]  firq_src;
    logic        unused_wdata_hi;

    assign unused_wdata_hi = ^MDATA_W[7:4];

    assign hit_fd01 = (MADDRBUS == ADDR_FD01);
    assign hit_fd02 = (MADDRBUS == ADDR_FD02);
    assign hit_fd03 = (MADDRBUS == ADDR_FD03);
    assign hit_fd04 = (MADDRBUS == ADDR_FD04);

    // eb_d resets low so an access cut short by reset never completes
    assign acc      = eb_d & ~EB;
    assign tmr_tick = (tmr_cnt == TMR_LAST);

    fm7_sync_edge #(.STAGES(SYNC_STAGES), .RISE(1'b1)) u_key (
        .clk(CLKSYS), .rst_n(RESETn), .din(KEYIRQ),  .pulse(key_set)
    );
    fm7_sync_edge #(.STAGES(SYNC_STAGES), .RISE(1'b0)) u_prn (
        .clk(CLKSYS), .rst_n(RESETn), .din(PRNACKn), .pulse(prn_set)
    );
    fm7_sync_edge #(.STAGES(SYNC_STAGES), .RISE(1'b0)) u_brk (
        .clk(CLKSYS), .rst_n(RESETn), .din(BREAKn),  .pulse(brk_set)
    );

    always_ff @(posedge CLKSYS or negedge RESETn) begin
        if (!RESETn) begin
            eb_d     <= 1'b0;
            tmr_cnt  <= '0;
            mask     <= '0;
            key_f    <= 1'b0;
            prn_f    <= 1'b0;
            tmr_f    <= 1'b0;
            att_f    <= 1'b0;
            brk_f    <= 1'b0;
            ext_sync <= '1;
        end else begin
            eb_d    <= EB;
            tmr_cnt <= tmr_tick ? '0 : tmr_cnt + 16'd1;

            ext_sync[0] <= EXTIRQn;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                ext_sync[i] <= ext_sync[i-1];
            end

            if (acc && !RWB && hit_fd02) begin
                mask <= MDATA_W[3:0];
            end

            // set term is OR-ed last so a coincident clearing read never drops an event
            key_f <= key_set  | (key_f & ~(acc & RWB & hit_fd01));
            prn_f <= prn_set  | (prn_f & ~(acc & RWB & hit_fd03));
            tmr_f <= tmr_tick | (tmr_f & ~(acc & RWB & hit_fd03));
            att_f <= ATTNP    | (att_f & ~(acc & RWB & hit_fd04));
            brk_f <= brk_set  | (brk_f & ~(acc & RWB & hit_fd04));
        end
    end

    assign ext = ~ext_sync[SYNC_STAGES-1];

    always_comb begin
        irq_src          = '0;
        irq_src[KEY_BIT] = key_f;
        irq_src[PRN_BIT] = prn_f;
        irq_src[TMR_BIT] = tmr_f;
        irq_src[EXT_BIT] = ext;
        firq_src          = '0;
        firq_src[ATT_BIT] = att_f;
        firq_src[BRK_BIT] = brk_f;
    end

    assign IRQn  = ~|(irq_src & mask);
    assign FIRQn = ~|firq_src;

    // gated by RESETn so the mux never selects this block during reset
    assign DOE = RESETn & RWB & EB & (hit_fd03 | hit_fd04);

    always_comb begin
        DOUT = 8'hFF;
        if (DOE) begin
            if (hit_fd03) DOUT = {4'hF, ~irq_src};
            else          DOUT = {6'h3F, ~firq_src};
        end
    end

endmodule

// File: tb/tb_fm7_main_irq_ctrl.sv
module tb_fm7_main_irq_ctrl;

    localparam int TDIV = 16;
    localparam int SS   = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] addr = 16'h0000;
    logic [7:0]  wdata = 8'h00;
    logic        rwb = 1'b1;
    logic        eb = 1'b0;
    logic        keyirq = 1'b0;
    logic        prnackn = 1'b1;
    logic        extirqn = 1'b1;
    logic        attnp = 1'b0;
    logic        breakn = 1'b1;
    logic        irqn, firqn, doe;
    logic [7:0]  dout;

    always #5 clk = ~clk;

    fm7_main_irq_ctrl #(.TIMER_DIV(TDIV), .SYNC_STAGES(SS)) dut (
        .CLKSYS(clk), .RESETn(rst_n), .MADDRBUS(addr), .MDATA_W(wdata),
        .RWB(rwb), .EB(eb), .KEYIRQ(keyirq), .PRNACKn(prnackn), .EXTIRQn(extirqn),
        .ATTNP(attnp), .BREAKn(breakn), .IRQn(irqn), .FIRQn(firqn),
        .DOUT(dout), .DOE(doe)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    // m_n counts rising edges since reset release. Histories hold the input value
    // seen in each past cycle, newest in bit 0; idle level fills them at reset.
    int          m_n;
    logic [3:0]  m_mask;
    logic        m_key, m_prn, m_tmr, m_att, m_brk, m_ext, m_ebd;
    logic [SS+1:0] h_key, h_prn, h_brk, h_ext;

    task automatic model_reset();
        m_n = 0; m_mask = 4'h0;
        m_key = 0; m_prn = 0; m_tmr = 0; m_att = 0; m_brk = 0; m_ext = 0; m_ebd = 0;
        h_key = '0; h_prn = '1; h_brk = '1; h_ext = '1;
    endtask

    task automatic model_edge();
        logic acc, rd, s_key, s_prn, s_brk, s_tmr;
        m_n++;
        h_key = {h_key[SS:0], keyirq};
        h_prn = {h_prn[SS:0], prnackn};
        h_brk = {h_brk[SS:0], breakn};
        h_ext = {h_ext[SS:0], extirqn};
        // an input change becomes a flag on the (SS+1)th edge
        s_key =  h_key[SS] & ~h_key[SS+1];
        s_prn = ~h_prn[SS] &  h_prn[SS+1];
        s_brk = ~h_brk[SS] &  h_brk[SS+1];
        s_tmr = (m_n % TDIV) == 0;
        acc   = m_ebd & ~eb;
        m_ebd = eb;
        rd    = acc & rwb;
        m_key = s_key | (m_key & !(rd && addr == 16'hFD01));
        m_prn = s_prn | (m_prn & !(rd && addr == 16'hFD03));
        m_tmr = s_tmr | (m_tmr & !(rd && addr == 16'hFD03));
        m_att = attnp | (m_att & !(rd && addr == 16'hFD04));
        m_brk = s_brk | (m_brk & !(rd && addr == 16'hFD04));
        if (acc && !rwb && addr == 16'hFD02) m_mask = wdata[3:0];
        m_ext = ~h_ext[SS-1];
    endtask

    function automatic logic e_irqn();
        return ({m_ext, m_tmr, m_prn, m_key} & m_mask) == 4'h0;
    endfunction
    function automatic logic e_firqn();
        return !(m_att || m_brk);
    endfunction
    function automatic logic e_doe();
        return rst_n && rwb && eb && (addr == 16'hFD03 || addr == 16'hFD04);
    endfunction
    function automatic logic [7:0] e_dout();
        if (!e_doe()) return 8'hFF;
        if (addr == 16'hFD03) return {4'hF, ~m_ext, ~m_tmr, ~m_prn, ~m_key};
        return {6'h3F, ~m_brk, ~m_att};
    endfunction

    // ---------------- cycle engine ----------------
    logic       s_irqn, s_firqn, s_doe;
    logic [7:0] s_dout;

    task automatic cycle();
        @(negedge clk);
        s_irqn = irqn; s_firqn = firqn; s_doe = doe; s_dout = dout;
        chk("cyc_irqn",  {15'd0, irqn},  {15'd0, e_irqn()});
        chk("cyc_firqn", {15'd0, firqn}, {15'd0, e_firqn()});
        chk("cyc_doe",   {15'd0, doe},   {15'd0, e_doe()});
        chk("cyc_dout",  {8'd0, dout},   {8'd0, e_dout()});
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic bus(input logic [15:0] a, input logic r, input logic e, input logic [7:0] d);
        addr = a; rwb = r; eb = e; wdata = d;
    endtask

    task automatic idle_bus();
        bus(16'h0000, 1'b1, 1'b0, 8'h00);
    endtask

    task automatic idle_until(input int target);
        idle_bus();
        for (int g = 0; g < 400 && m_n < target; g++) cycle();
        if (m_n != target) chk("sync_point", m_n[15:0], target[15:0]);
    endtask

    task automatic reg_access(input logic [15:0] a, input logic r, input logic [7:0] d);
        bus(a, r, 1'b1, d); cycle();
        eb = 1'b0;         cycle();
        idle_bus();
    endtask

    function automatic logic [15:0] pick_addr();
        case ($urandom_range(0, 5))
            0: return 16'hFD01;
            1: return 16'hFD02;
            2: return 16'hFD03;
            3: return 16'hFD04;
            4: return 16'hFD00;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic do_reset(input int ncyc);
        rst_n = 1'b0;
        model_reset();
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            chk("rst_irqn",  {15'd0, irqn},  16'd1);
            chk("rst_firqn", {15'd0, firqn}, 16'd1);
            chk("rst_doe",   {15'd0, doe},   16'd0);
            chk("rst_dout",  {8'd0, dout},   16'h00FF);
            @(posedge clk); #1;
            keyirq = 1'($urandom); prnackn = 1'($urandom); extirqn = 1'($urandom);
            attnp = 1'($urandom);  breakn = 1'($urandom);
            bus(pick_addr(), 1'($urandom), 1'($urandom), 8'($urandom));
        end
        keyirq = 0; prnackn = 1; extirqn = 1; attnp = 0; breakn = 1;
        idle_bus();
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [15:0] a;
        logic        r;
        logic        e;
        logic        x_doe;
        logic [7:0]  x_dout;
    } vec_t;

    vec_t tbl[10];

    initial begin
        tbl[0] = '{16'hFD03, 1'b1, 1'b1, 1'b1, 8'hFF};
        tbl[1] = '{16'hFD03, 1'b1, 1'b0, 1'b0, 8'hFF};
        tbl[2] = '{16'hFD04, 1'b1, 1'b1, 1'b1, 8'hFF};
        tbl[3] = '{16'hFD04, 1'b1, 1'b0, 1'b0, 8'hFF};
        tbl[4] = '{16'hFD02, 1'b1, 1'b1, 1'b0, 8'hFF};
        tbl[5] = '{16'hFD03, 1'b0, 1'b1, 1'b0, 8'hFF};
        tbl[6] = '{16'hFD03, 1'b0, 1'b0, 1'b0, 8'hFF};
        tbl[7] = '{16'hFE03, 1'b1, 1'b1, 1'b0, 8'hFF};
        tbl[8] = '{16'hFD05, 1'b1, 1'b1, 1'b0, 8'hFF};
        tbl[9] = '{16'hFD05, 1'b1, 1'b0, 1'b0, 8'hFF};

        // reset with toggling inputs
        do_reset(6);

        // decode table right after release, all flags clear
        foreach (tbl[i]) begin
            bus(tbl[i].a, tbl[i].r, tbl[i].e, 8'h00);
            cycle();
            chk($sformatf("tbl%0d_doe", i),  {15'd0, s_doe}, {15'd0, tbl[i].x_doe});
            chk($sformatf("tbl%0d_dout", i), {8'd0, s_dout}, {8'd0, tbl[i].x_dout});
        end

        // timer tick and acknowledge
        reg_access(16'hFD02, 1'b0, 8'h04);
        idle_until(TDIV - 1);
        cycle(); chk("tmr_before_tick", {15'd0, s_irqn}, 16'd1);
        cycle(); chk("tmr_tick_irq",    {15'd0, s_irqn}, 16'd0);
        bus(16'hFD03, 1'b1, 1'b1, 8'h00); cycle();
        chk("tmr_fd03", {8'd0, s_dout}, 16'h00FB);
        eb = 1'b0; cycle();
        idle_bus(); cycle();
        chk("tmr_ack_irq", {15'd0, s_irqn}, 16'd1);
        idle_until(2*TDIV - 1);
        cycle(); chk("tmr2_before", {15'd0, s_irqn}, 16'd1);
        cycle(); chk("tmr2_tick",   {15'd0, s_irqn}, 16'd0);

        // collision: read acc lands on the wrap edge
        reg_access(16'hFD03, 1'b1, 8'h00);
        idle_until(3*TDIV - 2);
        bus(16'hFD03, 1'b1, 1'b1, 8'h00); cycle();
        eb = 1'b0; cycle();
        idle_bus(); cycle();
        chk("coll_irq", {15'd0, s_irqn}, 16'd0);
        bus(16'hFD03, 1'b1, 1'b1, 8'h00); cycle();
        chk("coll_fd03", {8'd0, s_dout}, 16'h00FB);
        eb = 1'b0; cycle();
        idle_bus(); cycle();
        chk("coll_ack_irq", {15'd0, s_irqn}, 16'd1);

        // masking of KEY, then enable and keyboard acknowledge
        idle_until(52);
        reg_access(16'hFD02, 1'b0, 8'h00);
        keyirq = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cycle(); chk("key_masked", {15'd0, s_irqn}, 16'd1);
        end
        bus(16'hFD03, 1'b1, 1'b1, 8'h00); cycle();
        chk("key_fd03", {8'd0, s_dout}, 16'h00FE);
        eb = 1'b0; cycle();
        bus(16'hFD02, 1'b0, 1'b1, 8'h01); cycle();
        eb = 1'b0; cycle();
        chk("mask_acc_cycle", {15'd0, s_irqn}, 16'd1);
        bus(16'hFD01, 1'b1, 1'b1, 8'h00); cycle();
        chk("mask_after_acc", {15'd0, s_irqn}, 16'd0);
        eb = 1'b0; cycle();
        idle_bus(); keyirq = 1'b0; cycle();
        chk("key_ack_irq", {15'd0, s_irqn}, 16'd1);

        // PRN latency: flag visible on the 3rd edge after the fall
        bus(16'hFD03, 1'b1, 1'b1, 8'h00);
        prnackn = 1'b0;
        for (int i = 0; i < SS + 1; i++) begin
            cycle(); chk("prn_latency_pre", {15'd0, s_dout[1]}, 16'd1);
        end
        cycle(); chk("prn_latency_set", {15'd0, s_dout[1]}, 16'd0);
        eb = 1'b0; cycle();
        idle_bus(); prnackn = 1'b1; cycle();

        // ATT pulse
        attnp = 1'b1; cycle();
        chk("att_same_cycle", {15'd0, s_firqn}, 16'd1);
        attnp = 1'b0;
        bus(16'hFD04, 1'b1, 1'b1, 8'h00); cycle();
        chk("att_firq", {15'd0, s_firqn}, 16'd0);
        chk("att_fd04", {8'd0, s_dout}, 16'h00FE);
        eb = 1'b0; cycle();
        idle_bus(); cycle();
        chk("att_ack", {15'd0, s_firqn}, 16'd1);

        // BREAK falling edge
        breakn = 1'b0;
        for (int i = 0; i < SS + 1; i++) begin
            cycle(); chk("brk_pre", {15'd0, s_firqn}, 16'd1);
        end
        cycle(); chk("brk_set", {15'd0, s_firqn}, 16'd0);
        breakn = 1'b1;
        bus(16'hFD04, 1'b1, 1'b1, 8'h00); cycle();
        chk("brk_fd04", {8'd0, s_dout}, 16'h00FD);
        eb = 1'b0; cycle();
        idle_bus(); cycle();
        chk("brk_ack", {15'd0, s_firqn}, 16'd1);

        // EXT is a level, not latched
        reg_access(16'hFD02, 1'b0, 8'h08);
        extirqn = 1'b0;
        for (int i = 0; i < SS; i++) begin
            cycle(); chk("ext_pre", {15'd0, s_irqn}, 16'd1);
        end
        cycle(); chk("ext_on", {15'd0, s_irqn}, 16'd0);
        extirqn = 1'b1;
        for (int i = 0; i < SS; i++) begin
            cycle(); chk("ext_hold", {15'd0, s_irqn}, 16'd0);
        end
        cycle(); chk("ext_off", {15'd0, s_irqn}, 16'd1);

        // randomized traffic against the model
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 7) == 0) keyirq  = ~keyirq;
            if ($urandom_range(0, 7) == 0) prnackn = ~prnackn;
            if ($urandom_range(0, 9) == 0) extirqn = ~extirqn;
            if ($urandom_range(0, 7) == 0) breakn  = ~breakn;
            attnp = ($urandom_range(0, 9) == 0);
            if (eb) eb = 1'($urandom_range(0, 2) == 0);
            else begin
                bus(pick_addr(), 1'($urandom), 1'($urandom), 8'($urandom));
            end
            cycle();
        end
        attnp = 1'b0;

        // reset in the middle of a $FD02 write
        reg_access(16'hFD02, 1'b0, 8'h0F);
        attnp = 1'b1; cycle(); attnp = 1'b0;
        bus(16'hFD02, 1'b0, 1'b1, 8'h0F); cycle();
        #2;
        do_reset(4);
        extirqn = 1'b0;
        bus(16'hFD04, 1'b1, 1'b1, 8'h00); cycle();
        chk("mid_fd04", {8'd0, s_dout}, 16'h00FF);
        idle_bus(); cycle(); cycle(); cycle();
        bus(16'hFD03, 1'b1, 1'b1, 8'h00); cycle();
        chk("mid_fd03", {8'd0, s_dout}, 16'h00F7);
        chk("mid_mask_irq", {15'd0, s_irqn}, 16'd1);
        chk("mid_firq", {15'd0, s_firqn}, 16'd1);
        eb = 1'b0; cycle();
        idle_bus(); extirqn = 1'b1; cycle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
